// File: rtl/approx_add_arbiter.sv
// Round-robin sharing of one external 8-bit approximate adder among N_REQ requesters.
// Latency: accept -> rsp_valid after ADD_LAT+1 cycles; one operation per ADD_LAT+2 cycles at best.
// Backpressure: response held while rsp_ready=0, no new grant until it drains. Optional error monitor: ADD_ARB_ERRMON_EN.
module approx_add_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADD_LAT = 1,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    output logic [7:0]           add_a,
    output logic [7:0]           add_b,
    input  logic [8:0]           add_o,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [8:0]           rsp_data,
    output logic [ID_W-1:0]      rsp_id,
`ifdef ADD_ARB_ERRMON_EN
    input  logic                 err_clr,
    output logic [8:0]           err_last,
    output logic [8:0]           err_max,
`endif
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] cand;
    logic            gnt_found;
    logic [1:0]      cnt;
    logic [7:0]      sel_a;
    logic [7:0]      sel_b;
    logic            capture;

    // Search starts just after the last winner so it drops to lowest priority.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_idx == ID_W'(k)) begin
                sel_a = req_a[8*k +: 8];
                sel_b = req_b[8*k +: 8];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_found)
            req_ready[gnt_idx] = 1'b1;
    end

    assign busy    = (state != IDLE);
    assign capture = (state == WAIT) && (cnt == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            add_a     <= '0;
            add_b     <= '0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            rr_ptr    <= ID_W'(N_REQ - 1);
            grant_id  <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_found) begin
                    add_a    <= sel_a;
                    add_b    <= sel_b;
                    rr_ptr   <= gnt_idx;
                    grant_id <= gnt_idx;
                    cnt      <= 2'(ADD_LAT - 1);
                    state    <= WAIT;
                end
                // add_o is sampled exactly ADD_LAT edges after the operand registers change.
                WAIT: if (cnt == 2'd0) begin
                    rsp_data  <= add_o;
                    rsp_id    <= grant_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end else begin
                    cnt <= cnt - 2'd1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADD_ARB_ERRMON_EN
    logic [8:0] err_sum;
    logic [8:0] err_abs;

    assign err_sum = {1'b0, add_a} + {1'b0, add_b};
    assign err_abs = (err_sum >= add_o) ? (err_sum - add_o) : (add_o - err_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_last <= '0;
            err_max  <= '0;
        end else if (err_clr) begin
            err_last <= '0;
            err_max  <= '0;
        end else if (capture) begin
            err_last <= err_abs;
            if (err_abs > err_max)
                err_max <= err_abs;
        end
    end
`endif

endmodule

// File: tb/tb_approx_add_arbiter.sv
// Scoreboard bench: three arbiters (ADD_LAT 1, 3, 4) each driving a delayed bench adder model.
module tb_approx_add_arbiter;

    typedef struct {
        int inst;
        int id;
        int data;
    } exp_t;

    logic        clk;
    logic        rstn [3];
    logic [3:0]  rv   [3];
    logic [3:0]  rr   [3];
    logic [31:0] ra   [3];
    logic [31:0] rb   [3];
    logic [7:0]  aa   [3];
    logic [7:0]  ab   [3];
    logic [8:0]  ao   [3];
    logic        sv   [3];
    logic        sr   [3];
    logic [8:0]  sd   [3];
    logic [1:0]  sid  [3];
    logic        bsy  [3];
    int          bias [3];
`ifdef ADD_ARB_ERRMON_EN
    logic        ec   [3];
    logic [8:0]  el   [3];
    logic [8:0]  em   [3];
`endif

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g
        localparam int LAT = (i == 0) ? 1 : ((i == 1) ? 3 : 4);
        logic [8:0] pipe [0:3];
        wire  [8:0] exact = 9'(int'(aa[i]) + int'(ab[i]) + bias[i]);

        approx_add_arbiter #(.N_REQ(4), .ADD_LAT(LAT)) dut (
            .clk       (clk),
            .rst_n     (rstn[i]),
            .req_valid (rv[i]),
            .req_ready (rr[i]),
            .req_a     (ra[i]),
            .req_b     (rb[i]),
            .add_a     (aa[i]),
            .add_b     (ab[i]),
            .add_o     (ao[i]),
            .rsp_valid (sv[i]),
            .rsp_ready (sr[i]),
            .rsp_data  (sd[i]),
            .rsp_id    (sid[i]),
`ifdef ADD_ARB_ERRMON_EN
            .err_clr   (ec[i]),
            .err_last  (el[i]),
            .err_max   (em[i]),
`endif
            .busy      (bsy[i])
        );

        // Result only settles LAT edges after the operands change; earlier samples see stale data.
        always @(posedge clk) begin
            pipe[0] <= exact;
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign ao[i] = (LAT == 1) ? exact : pipe[(LAT > 1) ? LAT - 2 : 0];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input int inst, input int id, input int data);
        exp_t e;
        e.inst = inst;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Presents requests, checks the grant, records the expected response, waits for accept.
    task automatic issue(input int i, input logic [3:0] v, input int id, input int data, input bit expect_rsp);
        rv[i] = v;
        #1;
        chk("grant", int'(rr[i]), 1 << id);
        if (expect_rsp) push(i, id, data);
        tick();
        rv[i] = 4'b0000;
    endtask

    task automatic wait_rsp(input int i, input int lat);
        int n = 0;
        while (!sv[i] && n < 20) begin
            tick();
            n++;
        end
        chk("rsp_latency", n, lat);
        tick();
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rstn[i] && sv[i] && sr[i]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: inst %0d id %0d data 0x%0h, no response expected", i, sid[i], sd[i]);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.inst != i || mon_e.id != int'(sid[i]) || mon_e.data != int'(sd[i])) begin
                        errors++;
                        $display("FAIL rsp: got inst %0d id %0d data 0x%0h, expected inst %0d id %0d data 0x%0h",
                                 i, sid[i], sd[i], mon_e.inst, mon_e.id, mon_e.data);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rstn[i] = 1'b0;
            rv[i]   = '0;
            ra[i]   = '0;
            rb[i]   = '0;
            sr[i]   = 1'b1;
            bias[i] = 0;
`ifdef ADD_ARB_ERRMON_EN
            ec[i]   = 1'b0;
`endif
        end
        tick();
        tick();
        chk("rst_add_a", int'(aa[0]), 0);
        chk("rst_rsp_valid", int'(sv[0]), 0);
        chk("rst_busy", int'(bsy[0]), 0);
        chk("rst_req_ready", int'(rr[0]), 0);
        for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
        tick();

        // Single op with carry out.
        ra[0] = 32'h0000007F;
        rb[0] = 32'h00000081;
        issue(0, 4'b0001, 0, 'h100, 1);
        chk("busy_wait", int'(bsy[0]), 1);
        chk("add_a_reg", int'(aa[0]), 'h7F);
        wait_rsp(0, 1);

        // Contention from a fresh reset: 0,1,2,3,0 spaced ADD_LAT+2 apart.
        rstn[0] = 1'b0;
        tick();
        rstn[0] = 1'b1;
        ra[0] = {8'd40, 8'd30, 8'd20, 8'd10};
        rb[0] = {8'd4, 8'd3, 8'd2, 8'd1};
        rv[0] = 4'b1111;
        begin
            int last = 0;
            for (int n = 0; n < 5; n++) begin
                int w = 0;
                #1;
                while (rr[0] == 4'b0000 && w < 10) begin
                    tick();
                    w++;
                end
                chk("rr_order", int'(rr[0]), 1 << (n % 4));
                if (n > 0) chk("rr_spacing", cyc - last, 3);
                last = cyc;
                push(0, n % 4, 11 * ((n % 4) + 1));
                tick();
            end
        end
        rv[0] = 4'b0000;
        tick();
        tick();
        tick();

        // Backpressure: response held, no grant while waiting.
        ra[0] = 32'h00100000;
        rb[0] = 32'h00200000;
        issue(0, 4'b0100, 2, 'h30, 1);
        rv[0] = 4'b1111;
        sr[0] = 1'b0;
        tick();
        for (int n = 0; n < 5; n++) begin
            chk("hold_valid", int'(sv[0]), 1);
            chk("hold_data", int'(sd[0]), 'h30);
            chk("hold_id", int'(sid[0]), 2);
            chk("hold_ready", int'(rr[0]), 0);
            tick();
        end
        rv[0] = 4'b0000;
        sr[0] = 1'b1;
        tick();
        chk("bp_release", int'(sv[0]), 0);
        chk("bp_idle", int'(bsy[0]), 0);

        // Wraparound: last winner 2, so 3 then 0 are searched first.
        ra[0] = 32'h00000A03;
        rb[0] = 32'h00000B04;
        issue(0, 4'b0011, 0, 7, 1);
        wait_rsp(0, 1);

        // Reset in the second WAIT cycle with ADD_LAT=3.
        ra[1] = 32'h00050001;
        rb[1] = 32'h00060002;
        issue(1, 4'b0100, 2, 11, 0);
        tick();
        rstn[1] = 1'b0;
        #1;
        chk("midrst_add_a", int'(aa[1]), 0);
        chk("midrst_add_b", int'(ab[1]), 0);
        chk("midrst_busy", int'(bsy[1]), 0);
        chk("midrst_valid", int'(sv[1]), 0);
        tick();
        tick();
        chk("midrst_no_rsp", int'(sv[1]), 0);
        rstn[1] = 1'b1;
        tick();
        issue(1, 4'b1111, 0, 3, 1);
        wait_rsp(1, 3);

        // ADD_LAT=4 with maximal operands.
        ra[2] = 32'h000000FF;
        rb[2] = 32'h000000FF;
        issue(2, 4'b0001, 0, 'h1FE, 1);
        wait_rsp(2, 4);

`ifdef ADD_ARB_ERRMON_EN
        bias[0] = -42;
        ra[0] = 32'h00006400;
        rb[0] = 32'h00003C00;
        issue(0, 4'b0010, 1, 118, 1);
        wait_rsp(0, 1);
        chk("err_last_42", int'(el[0]), 42);
        chk("err_max_42", int'(em[0]), 42);
        bias[0] = 5;
        ra[0] = 32'h00000A00;
        rb[0] = 32'h00001400;
        issue(0, 4'b0010, 1, 35, 1);
        wait_rsp(0, 1);
        chk("err_last_5", int'(el[0]), 5);
        chk("err_max_keep", int'(em[0]), 42);
        ec[0] = 1'b1;
        tick();
        ec[0] = 1'b0;
        chk("err_last_clr", int'(el[0]), 0);
        chk("err_max_clr", int'(em[0]), 0);
        bias[0] = 0;
`endif

        tick();
        tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/approx_add_arbiter.md
Name: approx_add_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one external 8-bit unsigned approximate adder (9-bit result) among N_REQ requesters.
- Accepts operand pairs over valid/ready and registers them onto the adder inputs.
- Waits a configurable adder latency, then captures the sum and returns it with the requester ID over a valid/ready response channel.
- Any add8u variant plugs in unchanged at the add_a/add_b/add_o boundary.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADD_LAT, 1, cycles from an add_a/add_b register update to a stable add_o (1..4).
- ID_W, derived localparam = max(1, ceil(log2(N_REQ))), width of rsp_id.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_a  in  8*N_REQ  operand A; requester i on bits [8i+7:8i].
- req_b  in  8*N_REQ  operand B; same packing as req_a.
- add_a  out  8  registered operand A to the shared adder.
- add_b  out  8  registered operand B to the shared adder.
- add_o  in  9  adder result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  9  captured sum.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE; add_a, add_b, rsp_data, rsp_id = 0; rsp_valid=0; rr_ptr=N_REQ-1; wait counter=0. Any in-flight transaction is dropped; its requester must re-present.
- Grant (combinational, IDLE only): the first index with req_valid=1, searching from rr_ptr+1 upward with wrap modulo N_REQ. req_ready is one-hot at that index. req_ready=0 in all other states or when no request is valid.
- Accept = req_valid[g] & req_ready[g]. On accept:
  - add_a <= req_a[g], add_b <= req_b[g].
  - rr_ptr <= g, grant_id <= g.
  - counter <= ADD_LAT-1; state -> WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0:
  - rsp_data <= add_o, rsp_id <= grant_id, rsp_valid <= 1; state -> RESP.
  - add_o is therefore sampled exactly ADD_LAT cycles after the operand register update.
- RESP:
  - rsp_valid, rsp_data and rsp_id hold stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: rsp_valid <= 0; state -> IDLE.
  - A new grant is possible in the cycle after the return to IDLE.
- Throughput: one operation per ADD_LAT+2 cycles minimum. No overlap between operations.
- add_a/add_b keep their value until the next accept. They do not return to 0 after a response.
- Requesters may drop req_valid before acceptance without effect. Operands are sampled only on accept.
- No request valid in IDLE: stay in IDLE, rr_ptr unchanged.
- Simultaneous requests: strict round-robin. After reset, requester 0 has highest priority. A requester granted in one round has lowest priority in the next.
- Arithmetic: no modification of add_o; the full 9 bits pass through, including the carry in bit 8.

Optional Feature:
- Macro ADD_ARB_ERRMON_EN.
- Defined: adds ports err_clr (in, 1), err_last (out, 9) and err_max (out, 9).
  - On each capture: err_last <= |(add_a + add_b) - add_o|, computed on 9 bits from the registered operands.
  - err_max <= max(err_max, new err_last).
  - err_clr=1 zeroes both on the next edge. If err_clr and a capture occur in the same cycle, err_clr wins.
  - Both reset to 0.
- Not defined: the three ports and all monitor logic are absent. Arbitration and timing are identical.

Test Plan:
- Single op, ADD_LAT=1, exact bench adder: req_valid=0001, a=0x7F, b=0x81 -> req_ready[0] high the same cycle; rsp_valid 2 cycles later with rsp_data=0x100, rsp_id=0.
- Contention: all 4 requesters valid continuously after reset -> grant order 0,1,2,3,0; each grant separated by ADD_LAT+2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_id held; req_ready stays 0; completes one cycle after rsp_ready rises.
- Reset mid-WAIT with ADD_LAT=3: pull rst_n low in the 2nd WAIT cycle -> immediate outputs 0, busy=0, no response; requester 0 wins the next grant.
- ADD_LAT=4: a=0xFF, b=0xFF -> add_o sampled exactly 4 cycles after the operand update; rsp_data=0x1FE.
- ERRMON:
  - Bench adder returns add_o=118 for a=100, b=60 -> err_last=42, err_max=42.
  - Next op with error 5 -> err_last=5, err_max=42.
  - err_clr pulse -> err_last=0, err_max=0.
